multicore_system_rom_loader: RTL and testbench

- Boot-image loader directly upstream of a Nios core's 4096x32 dual-port on-chip program memory. It drives that memory's second Avalon slave port.
- Consumes a byte stream (from a JTAG/UART bridge) and assembles little-endian 32-bit words. Writes them sequentially from word address 0.
- Reads the image back to verify a 32-bit additive checksum.
- Holds the owning core in reset until the image is verified.

---
 rtl/multicore_loader_pkg.sv | 22 ++
 rtl/multicore_system_rom_loader_if.sv | 29 ++
 rtl/multicore_system_rom_loader_asm.sv | 40 ++++
 rtl/multicore_system_rom_loader.sv | 170 +++++++++++++++++
 tb/tb_multicore_system_rom_loader.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicore_loader_pkg.sv
// Shared types and sizing for the boot-image loader: FSM states, memory geometry
// and the byte-lane index used by the word assembler.
package multicore_loader_pkg;

    localparam int LOADER_ADDR_W = 12;
    localparam int LOADER_DEPTH  = 4096;

    typedef enum logic [3:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        CSUM,
        VERIFY,
        CHECK,
        DONE,
        ERR
    } state_t;

    typedef logic [1:0] lane_t;

endpackage

// File: rtl/multicore_system_rom_loader_if.sv
// Byte-stream input and program-memory port 2 of the boot-image loader.
// The loader is the master: it accepts stream bytes and drives the memory slave port.
interface multicore_system_rom_loader_if #(
    parameter int ADDR_W = 12
);
    logic [7:0]        st_data;
    logic              st_valid;
    logic              st_ready;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [3:0]        mem_byteenable;
    logic [31:0]       mem_writedata;
    logic              mem_clken;
    logic [31:0]       mem_readdata;

    modport master (
        input  st_data, st_valid, mem_readdata,
        output st_ready, mem_address, mem_chipselect, mem_write,
               mem_byteenable, mem_writedata, mem_clken
    );

    modport slave (
        output st_data, st_valid, mem_readdata,
        input  st_ready, mem_address, mem_chipselect, mem_write,
               mem_byteenable, mem_writedata, mem_clken
    );
endinterface

// File: rtl/multicore_system_rom_loader_asm.sv
// Little-endian byte-to-word assembler. word_valid pulses combinationally on the
// fourth accepted byte, with word already carrying that byte in lane 3.
module multicore_system_rom_loader_asm
    import multicore_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    lane_t       lane;
    logic [23:0] low;

    // NOTE: clocked state is always assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane <= '0;
            low  <= '0;
        end else if (clear) begin
            lane <= '0;
            low  <= '0;
        end else if (byte_en) begin
            case (lane)
                2'd0:    low[7:0]   <= byte_data;
                2'd1:    low[15:8]  <= byte_data;
                2'd2:    low[23:16] <= byte_data;
                default: ;
            endcase
            lane <= lane + 2'd1;
        end
    end

    assign word       = {byte_data, low};
    assign word_valid = byte_en && (lane == 2'd3);

endmodule

// File: rtl/multicore_system_rom_loader.sv
// Boot-image loader: writes a length-prefixed image into program memory, reads it
// back against an additive checksum, and releases the owning core once verified.
module multicore_system_rom_loader #(
    parameter int ADDR_W = multicore_loader_pkg::LOADER_ADDR_W,
    parameter int DEPTH  = multicore_loader_pkg::LOADER_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    multicore_system_rom_loader_if.master bus,
    output logic                          core_reset_req,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [ADDR_W:0]               words_loaded
);
    import multicore_loader_pkg::*;

    localparam logic [ADDR_W:0]   WL_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [15:0]       n_words;
    logic [31:0]       csum, wsum, rsum;
    logic              mem_cs_q, mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              rd_valid, rd_last;

    logic              st_ready_c, accept, idle_like;
    logic              asm_en, asm_clear, word_valid;
    logic [31:0]       word;
    logic [15:0]       n_full;
    logic              last_word, last_addr;

    assign idle_like      = (state == IDLE) || (state == DONE) || (state == ERR);
    assign busy           = !idle_like;
    assign done           = (state == DONE);
    assign error          = (state == ERR);
    assign core_reset_req = (state != DONE);

    assign accept    = bus.st_valid && st_ready_c;
    assign asm_en    = accept && ((state == DATA) || (state == CSUM));
    assign asm_clear = idle_like && start;
    assign n_full    = {bus.st_data, n_words[7:0]};
    assign last_word = (32'(words_loaded) + 32'd1) == 32'(n_words);
    assign last_addr = (32'(mem_addr_q) + 32'd1) == 32'(n_words);

    assign bus.st_ready       = st_ready_c;
    assign bus.mem_address    = mem_addr_q;
    assign bus.mem_chipselect = mem_cs_q;
    assign bus.mem_write      = mem_wr_q;
    assign bus.mem_writedata  = mem_wdata_q;
    assign bus.mem_byteenable = 4'hF;
    assign bus.mem_clken      = 1'b1;

    multicore_system_rom_loader_asm u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_en    (asm_en),
        .byte_data  (bus.st_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // Back-pressure during the write cycle keeps exactly one write per four bytes.
    always_comb begin
        st_ready_c = 1'b0;
        case (state)
            HDR0, HDR1, CSUM: st_ready_c = 1'b1;
            DATA:             st_ready_c = !mem_wr_q;
            default:          st_ready_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: state_nxt gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nxt = HDR0;
            HDR0:            if (accept) state_nxt = HDR1;
            HDR1: begin
                if (accept) begin
                    if (32'(n_full) > 32'(DEPTH)) state_nxt = ERR;
                    else if (n_full == 16'd0)     state_nxt = CSUM;
                    else                          state_nxt = DATA;
                end
            end
            DATA:   if (mem_wr_q && last_word) state_nxt = CSUM;
            CSUM:   if (word_valid) state_nxt = (n_words == 16'd0) ? CHECK : VERIFY;
            VERIFY: if (rd_valid && rd_last) state_nxt = CHECK;
            CHECK:  state_nxt = ((wsum == csum) && (rsum == csum)) ? DONE : ERR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_words      <= '0;
            csum         <= '0;
            wsum         <= '0;
            rsum         <= '0;
            words_loaded <= '0;
            mem_cs_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rd_valid     <= 1'b0;
            rd_last      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        n_words      <= '0;
                        csum         <= '0;
                        wsum         <= '0;
                        rsum         <= '0;
                        words_loaded <= '0;
                        mem_cs_q     <= 1'b0;
                        mem_wr_q     <= 1'b0;
                    end
                end
                HDR0: if (accept) n_words[7:0]  <= bus.st_data;
                HDR1: if (accept) n_words[15:8] <= bus.st_data;
                DATA: begin
                    if (mem_wr_q) begin
                        mem_cs_q     <= 1'b0;
                        mem_wr_q     <= 1'b0;
                        wsum         <= wsum + mem_wdata_q;
                        words_loaded <= words_loaded + WL_ONE;
                    end else if (word_valid) begin
                        mem_cs_q    <= 1'b1;
                        mem_wr_q    <= 1'b1;
                        mem_addr_q  <= words_loaded[ADDR_W-1:0];
                        mem_wdata_q <= word;
                    end
                end
                CSUM: begin
                    if (word_valid) begin
                        csum <= word;
                        if (n_words != 16'd0) begin
                            mem_cs_q   <= 1'b1;
                            mem_addr_q <= '0;
                        end
                    end
                end
                VERIFY: begin
                    // Read data lands one cycle after its address; rd_valid/rd_last track that lag.
                    if (mem_cs_q) begin
                        rd_valid <= 1'b1;
                        rd_last  <= last_addr;
                        if (last_addr) mem_cs_q   <= 1'b0;
                        else           mem_addr_q <= mem_addr_q + ADDR_ONE;
                    end
                    if (rd_valid) rsum <= rsum + bus.mem_readdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicore_system_rom_loader.sv
// Scoreboarded bench for the boot-image loader: a task streams images and queues the
// expected memory writes, a monitor checks writes/reads, and outcomes come from a plain model.
module tb_multicore_system_rom_loader;
    import multicore_loader_pkg::*;

    localparam int AW    = LOADER_ADDR_W;
    localparam int DEPTH = LOADER_DEPTH;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          core_reset_req, busy, done, error;
    logic [AW:0]   words_loaded;

    multicore_system_rom_loader_if #(.ADDR_W(AW)) bus ();

    multicore_system_rom_loader #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .bus            (bus),
        .core_reset_req (core_reset_req),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .words_loaded   (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    int          rd_count = 0;
    wr_t         exp_wr[$];
    logic [31:0] img [0:DEPTH-1];
    logic [31:0] mem [0:DEPTH-1];
    logic        corrupt_en;
    logic [AW-1:0] corrupt_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // NOTE: the memory array has no reset; only written locations are ever read back.
    always @(posedge clk) begin
        if (bus.mem_chipselect) begin
            if (bus.mem_write) mem[bus.mem_address] <= bus.mem_writedata;
            else bus.mem_readdata <= mem[bus.mem_address] ^
                 ((corrupt_en && bus.mem_address == corrupt_addr) ? 32'h1 : 32'h0);
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (!reset && bus.mem_chipselect) begin
            if (bus.mem_write) begin
                if (exp_wr.size() == 0) fail_event("unexpected_write");
                else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(bus.mem_address), 32'(e.addr));
                    check("wr_data", bus.mem_writedata, e.data);
                    check("wr_byteenable", 32'(bus.mem_byteenable), 32'hF);
                end
            end else begin
                rd_count++;
            end
        end
    end

    function automatic logic [31:0] model_sum(input int n);
        logic [31:0] s = 32'h0;
        for (int i = 0; i < n; i++) s += img[i];
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.st_data  = b;
        bus.st_valid = 1'b1;
        while (!bus.st_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.st_ready) begin
            fail_event("st_ready_wait");
            bus.st_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.st_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Streams one image and checks the final outcome against the model.
    task automatic run_load(input int n, input logic [31:0] c, input int gap,
                            input int corrupt_idx, input bit mid_start);
        logic [31:0] sum;
        logic [15:0] n16 = 16'(n);
        bit          exp_done;
        int          exp_reads, exp_wl, rd_base, budget, limit;
        wr_t         e;

        sum       = (n <= DEPTH) ? model_sum(n) : 32'h0;
        exp_done  = (n <= DEPTH) && (sum == c) && (corrupt_idx < 0);
        exp_reads = (n >= 1 && n <= DEPTH) ? n : 0;
        exp_wl    = (n <= DEPTH) ? n : 0;
        corrupt_en   = (corrupt_idx >= 0);
        corrupt_addr = AW'((corrupt_idx >= 0) ? corrupt_idx : 0);
        if (n <= DEPTH) begin
            for (int i = 0; i < n; i++) begin
                e.addr = AW'(i);
                e.data = img[i];
                exp_wr.push_back(e);
            end
        end
        rd_base = rd_count;

        pulse_start();
        send_byte(n16[7:0], gap);
        send_byte(n16[15:8], gap);
        if (n <= DEPTH) begin
            for (int i = 0; i < n; i++) begin
                if (mid_start && i == n / 2) pulse_start();
                send_word(img[i], gap);
            end
            send_word(c, gap);
        end

        budget = 0;
        limit  = 64 * n + 500;
        while (!(done || error) && budget < limit) begin
            @(negedge clk);
            budget++;
        end
        if (!(done || error)) fail_event("completion_wait");
        repeat (2) @(negedge clk);

        check("done", 32'(done), 32'(exp_done));
        check("error", 32'(error), 32'(!exp_done));
        check("core_reset_req", 32'(core_reset_req), 32'(!exp_done));
        check("busy", 32'(busy), 32'h0);
        check("st_ready_final", 32'(bus.st_ready), 32'h0);
        check("words_loaded", 32'(words_loaded), 32'(exp_wl));
        check("read_count", 32'(rd_count - rd_base), 32'(exp_reads));
        check("writes_outstanding", 32'(exp_wr.size()), 32'h0);
        exp_wr.delete();
        corrupt_en = 1'b0;
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        int          n;

        reset        = 1'b1;
        start        = 1'b0;
        bus.st_valid = 1'b0;
        bus.st_data  = 8'h00;
        bus.mem_readdata = 32'h0;
        corrupt_en   = 1'b0;
        corrupt_addr = '0;
        repeat (3) @(negedge clk);

        check("rst_core_reset_req", 32'(core_reset_req), 32'h1);
        check("rst_st_ready", 32'(bus.st_ready), 32'h0);
        check("rst_chipselect", 32'(bus.mem_chipselect), 32'h0);
        check("rst_write", 32'(bus.mem_write), 32'h0);
        check("rst_address", 32'(bus.mem_address), 32'h0);
        check("rst_writedata", bus.mem_writedata, 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_words_loaded", 32'(words_loaded), 32'h0);
        reset = 1'b0;

        img[0] = 32'h11223344;
        img[1] = 32'hAABBCCDD;
        img[2] = 32'h00000001;
        run_load(3, 32'hBBDE0022, 0, -1, 1'b0);
        run_load(3, 32'hBBDE0023, 0, -1, 1'b0);
        run_load(32'h1001, 32'h0, 0, -1, 1'b0);
        run_load(0, 32'h0, 0, -1, 1'b0);

        img[0] = 32'hCAFEF00D;
        img[1] = 32'h0BADBEEF;
        run_load(2, model_sum(2), 5, 1, 1'b0);

        // Reset in the middle of DATA after one word has been written.
        img[0] = 32'h5A5A1234;
        begin
            wr_t e;
            e.addr = '0;
            e.data = img[0];
            exp_wr.push_back(e);
        end
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        send_word(img[0], 0);
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        check("mid_reset_words_loaded", 32'(words_loaded), 32'h1);
        check("mid_reset_writes_seen", 32'(exp_wr.size()), 32'h0);
        exp_wr.delete();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_core_reset_req", 32'(core_reset_req), 32'h1);
        check("arst_st_ready", 32'(bus.st_ready), 32'h0);
        check("arst_chipselect", 32'(bus.mem_chipselect), 32'h0);
        check("arst_write", 32'(bus.mem_write), 32'h0);
        check("arst_address", 32'(bus.mem_address), 32'h0);
        check("arst_writedata", bus.mem_writedata, 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_words_loaded", 32'(words_loaded), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        img[0] = 32'h87654321;
        run_load(1, 32'h87654321, 0, -1, 1'b0);

        for (int t = 0; t < 6; t++) begin
            n = int'($urandom_range(1, 24));
            for (int i = 0; i < n; i++) img[i] = $urandom;
            s = model_sum(n);
            if ($urandom_range(0, 3) == 0) s = s + 32'($urandom_range(1, 1000));
            run_load(n, s, int'($urandom_range(0, 2)), -1, 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
        run_load(DEPTH, model_sum(DEPTH), 0, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
